// File: rtl/stage_buffer.sv
// Valid/ready elastic buffer placed between pipeline stages, with configurable
// payload width, depth, optional empty-bypass, and a synchronous flush.
module stage_buffer #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 2,
    parameter int FALLTHROUGH = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             live_q, live_d;

    logic empty;
    logic bypass;
    logic push;
    logic pop;
    logic store;
    logic dequeue;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        empty  = (count_q == '0);
        // live_q holds in_ready and the bypass path low until the first edge after reset
        bypass = (FALLTHROUGH != 0) && empty && live_q && in_valid;

        in_ready  = live_q && !flush && (count_q < DEPTH_C);
        out_valid = !flush && (!empty || bypass);
        out_data  = bypass ? in_data : mem_q[rd_ptr_q];

        push    = in_valid && in_ready;
        pop     = out_valid && out_ready;
        store   = push && !(bypass && pop);
        dequeue = pop && !bypass;

        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        live_d   = 1'b1;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store) begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (dequeue) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({store, dequeue})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            live_q   <= live_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_stage_buffer.sv
// Bench for stage_buffer: four instances (D2, D3, D2 fallthrough, D1) driven
// together and compared each cycle against a queue-based reference model.
module tb_stage_buffer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0]       iv, orr, fl;
    logic [3:0][31:0] idt;
    wire  [3:0]       ir, ov;
    wire  [3:0][31:0] od;
    wire  [1:0]       c0, c1, c2;
    wire              c3;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq [4][$];
    logic        m_live = 1'b0;
    logic        e_ir [4];
    logic        e_ov [4];
    logic [31:0] e_od [4];
    int          e_cnt [4];
    logic        m_push [4];
    logic        m_pop [4];

    always #5 clk = ~clk;

    stage_buffer #(.WIDTH(32), .DEPTH(2), .FALLTHROUGH(0)) u_d2 (
        .clk(clk), .reset(reset), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(idt[0]), .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od[0]), .count(c0));
    stage_buffer #(.WIDTH(32), .DEPTH(3), .FALLTHROUGH(0)) u_d3 (
        .clk(clk), .reset(reset), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(idt[1]), .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od[1]), .count(c1));
    stage_buffer #(.WIDTH(32), .DEPTH(2), .FALLTHROUGH(1)) u_ft (
        .clk(clk), .reset(reset), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(idt[2]), .out_valid(ov[2]), .out_ready(orr[2]), .out_data(od[2]), .count(c2));
    stage_buffer #(.WIDTH(32), .DEPTH(1), .FALLTHROUGH(0)) u_d1 (
        .clk(clk), .reset(reset), .flush(fl[3]), .in_valid(iv[3]), .in_ready(ir[3]),
        .in_data(idt[3]), .out_valid(ov[3]), .out_ready(orr[3]), .out_data(od[3]), .count(c3));

    function automatic int dep_of(input int k);
        case (k)
            1:       return 3;
            3:       return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int cnt_of(input int k);
        case (k)
            0:       return int'(c0);
            1:       return int'(c1);
            2:       return int'(c2);
            default: return int'(c3);
        endcase
    endfunction

    // Reference: a FIFO of held beats; an empty fallthrough buffer shows in_data directly.
    task automatic model_expect(input int k);
        int sz;
        logic byp;
        sz  = mq[k].size();
        byp = (k == 2) && (sz == 0) && m_live && iv[k];
        e_ir[k]  = m_live && !fl[k] && (sz < dep_of(k));
        e_ov[k]  = !fl[k] && ((sz != 0) || byp);
        e_od[k]  = (sz != 0) ? mq[k][0] : idt[k];
        e_cnt[k] = sz;
    endtask

    task automatic model_update(input int k);
        model_expect(k);
        m_push[k] = iv[k] && e_ir[k];
        m_pop[k]  = e_ov[k] && orr[k];
        if (reset) begin
            mq[k].delete();
            m_push[k] = 1'b0;
            m_pop[k]  = 1'b0;
        end else if (fl[k]) begin
            mq[k].delete();
        end else if (!(mq[k].size() == 0 && m_push[k] && m_pop[k])) begin
            if (m_pop[k])  void'(mq[k].pop_front());
            if (m_push[k]) mq[k].push_back(idt[k]);
        end
    endtask

    task automatic advance();
        for (int k = 0; k < 4; k++) model_update(k);
        if (!reset) m_live = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iv = '0; orr = '0; fl = '0; idt = '0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                checks++; if (ov[k] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d] got %b want 0", k, ov[k]); end
                checks++; if (ir[k] !== 1'b0) begin errors++; $display("FAIL reset_in_ready[%0d] got %b want 0", k, ir[k]); end
                checks++; if (cnt_of(k) != 0) begin errors++; $display("FAIL reset_count[%0d] got %0d want 0", k, cnt_of(k)); end
                checks++; if (od[k] !== 32'h0) begin errors++; $display("FAIL reset_out_data[%0d] got %h want 0", k, od[k]); end
            end
            advance();
        end
        reset = 1'b0;
        @(negedge clk);
        advance();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++; if (ir[k] !== 1'b1) begin errors++; $display("FAIL release_in_ready[%0d] got %b want 1", k, ir[k]); end
            checks++; if (ov[k] !== 1'b0) begin errors++; $display("FAIL release_out_valid[%0d] got %b want 0", k, ov[k]); end
        end
        advance();
    endtask

    task automatic test_stream();
        idle_inputs();
        orr[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            iv[0]  = (i < 8);
            idt[0] = 32'(i + 1);
            @(negedge clk);
            model_expect(0);
            checks++; if (ir[0] !== e_ir[0]) begin errors++; $display("FAIL stream_in_ready got %b want %b", ir[0], e_ir[0]); end
            checks++; if (ov[0] !== e_ov[0]) begin errors++; $display("FAIL stream_out_valid got %b want %b", ov[0], e_ov[0]); end
            checks++; if (cnt_of(0) > 1) begin errors++; $display("FAIL stream_count got %0d want <=1", cnt_of(0)); end
            if (i >= 1 && i <= 8) begin
                checks++;
                if (ov[0] !== 1'b1 || od[0] !== 32'(i)) begin
                    errors++; $display("FAIL stream_latency got valid %b data %h want valid 1 data %h", ov[0], od[0], 32'(i));
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] seq [4];
        int pi, po, cyc;
        seq[0] = 32'hA; seq[1] = 32'hB; seq[2] = 32'hC; seq[3] = 32'hD;
        pi = 0; po = 0;
        idle_inputs();
        for (cyc = 0; cyc < 40 && po < 4; cyc++) begin
            iv[1]  = (pi < 4);
            idt[1] = (pi < 4) ? seq[pi] : 32'h0;
            orr[1] = (cyc >= 6);
            @(negedge clk);
            model_expect(1);
            checks++; if (ir[1] !== e_ir[1]) begin errors++; $display("FAIL bp_in_ready got %b want %b", ir[1], e_ir[1]); end
            checks++; if (cnt_of(1) != e_cnt[1]) begin errors++; $display("FAIL bp_count got %0d want %0d", cnt_of(1), e_cnt[1]); end
            if (cyc == 5) begin
                checks++;
                if (cnt_of(1) != 3 || ir[1] !== 1'b0 || od[1] !== 32'hA) begin
                    errors++; $display("FAIL bp_full got count %0d ready %b head %h want 3 0 a", cnt_of(1), ir[1], od[1]);
                end
            end
            if (e_ov[1] && orr[1]) begin
                checks++;
                if (ov[1] !== 1'b1 || od[1] !== seq[po]) begin
                    errors++; $display("FAIL bp_order got valid %b data %h want valid 1 data %h", ov[1], od[1], seq[po]);
                end
                po++;
            end
            advance();
            if (m_push[1]) pi++;
        end
        checks++;
        if (po != 4) begin errors++; $display("FAIL bp_timeout got %0d beats want 4", po); end
        idle_inputs();
    endtask

    task automatic test_flush();
        for (int s = 0; s < 7; s++) begin
            idle_inputs();
            case (s)
                0: begin iv[0] = 1'b1; idt[0] = 32'h11; end
                1: begin iv[0] = 1'b1; idt[0] = 32'h22; end
                2: begin iv[0] = 1'b1; idt[0] = 32'h33; fl[0] = 1'b1; orr[0] = 1'b1; end
                4: begin iv[0] = 1'b1; idt[0] = 32'h44; orr[0] = 1'b1; end
                5: orr[0] = 1'b1;
                default: ;
            endcase
            @(negedge clk);
            model_expect(0);
            checks++; if (cnt_of(0) != e_cnt[0]) begin errors++; $display("FAIL flush_count got %0d want %0d", cnt_of(0), e_cnt[0]); end
            if (s == 2) begin
                checks++;
                if (ov[0] !== 1'b0 || ir[0] !== 1'b0) begin errors++; $display("FAIL flush_cycle got valid %b ready %b want 0 0", ov[0], ir[0]); end
            end
            if (s == 3) begin
                checks++;
                if (cnt_of(0) != 0 || ov[0] !== 1'b0) begin errors++; $display("FAIL flush_after got count %0d valid %b want 0 0", cnt_of(0), ov[0]); end
            end
            if (s == 5) begin
                checks++;
                if (ov[0] !== 1'b1 || od[0] !== 32'h44) begin errors++; $display("FAIL flush_next got valid %b data %h want 1 44", ov[0], od[0]); end
            end
            advance();
        end
    endtask

    task automatic test_fallthrough();
        for (int s = 0; s < 6; s++) begin
            idle_inputs();
            case (s)
                0: begin iv[2] = 1'b1; idt[2] = 32'h55; orr[2] = 1'b1; end
                2: begin iv[2] = 1'b1; idt[2] = 32'h55; end
                4: orr[2] = 1'b1;
                default: ;
            endcase
            @(negedge clk);
            model_expect(2);
            checks++; if (ov[2] !== e_ov[2]) begin errors++; $display("FAIL ft_out_valid got %b want %b", ov[2], e_ov[2]); end
            if (s == 0 || s == 2 || s == 3) begin
                checks++;
                if (ov[2] !== 1'b1 || od[2] !== 32'h55) begin errors++; $display("FAIL ft_data got valid %b data %h want 1 55", ov[2], od[2]); end
            end
            if (s == 1 || s == 5) begin
                checks++; if (cnt_of(2) != 0) begin errors++; $display("FAIL ft_count_empty got %0d want 0", cnt_of(2)); end
            end
            if (s == 3) begin
                checks++; if (cnt_of(2) != 1) begin errors++; $display("FAIL ft_count_held got %0d want 1", cnt_of(2)); end
            end
            advance();
        end
    endtask

    task automatic test_depth1();
        int pushes;
        pushes = 0;
        idle_inputs();
        for (int c = 0; c < 10; c++) begin
            iv[3]  = 1'b1;
            orr[3] = 1'b1;
            idt[3] = 32'(32'h100 + c);
            @(negedge clk);
            model_expect(3);
            checks++; if (ir[3] !== ((c % 2) == 0)) begin errors++; $display("FAIL d1_in_ready cycle %0d got %b want %b", c, ir[3], (c % 2) == 0); end
            if (e_ov[3]) begin
                checks++; if (od[3] !== e_od[3]) begin errors++; $display("FAIL d1_data got %h want %h", od[3], e_od[3]); end
            end
            advance();
            if (m_push[3]) pushes++;
        end
        checks++;
        if (pushes != 5) begin errors++; $display("FAIL d1_rate got %0d transfers want 5", pushes); end
        idle_inputs();
        advance();
        advance();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc == 300) begin
                reset = 1'b1;
                for (int k = 0; k < 4; k++) mq[k].delete();
                m_live = 1'b0;
            end
            if (cyc == 302) reset = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!(iv[k] && !m_push[k] && !fl[k])) begin
                    iv[k]  = ($urandom_range(0, 3) != 0);
                    idt[k] = $urandom;
                end
                orr[k] = ($urandom_range(0, 9) < 7);
                fl[k]  = ($urandom_range(0, 15) == 0);
            end
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                model_expect(k);
                checks++; if (ir[k] !== e_ir[k]) begin errors++; $display("FAIL rnd_in_ready[%0d] cyc %0d got %b want %b", k, cyc, ir[k], e_ir[k]); end
                checks++; if (ov[k] !== e_ov[k]) begin errors++; $display("FAIL rnd_out_valid[%0d] cyc %0d got %b want %b", k, cyc, ov[k], e_ov[k]); end
                checks++; if (cnt_of(k) != e_cnt[k]) begin errors++; $display("FAIL rnd_count[%0d] cyc %0d got %0d want %0d", k, cyc, cnt_of(k), e_cnt[k]); end
                if (e_ov[k]) begin
                    checks++; if (od[k] !== e_od[k]) begin errors++; $display("FAIL rnd_out_data[%0d] cyc %0d got %h want %h", k, cyc, od[k], e_od[k]); end
                end
            end
            advance();
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            m_push[k] = 1'b0;
            m_pop[k]  = 1'b0;
        end
        idle_inputs();
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_fallthrough();
        test_depth1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
